// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package serial_add_sequencer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Bit-counter width for a given operand width (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Handshake and operand/result bus of the serial add/subtract engine.
interface serial_add_sequencer_if
  import serial_add_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             sub;
  logic             abort;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Requester side: issues operations, observes results.
  modport master (
    output start, op_a, op_b, cin, sub, abort,
    input  ready, done, sum, cout, ovf
  );

  // Engine side.
  modport slave (
    input  start, op_a, op_b, cin, sub, abort,
    output ready, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_add_sequencer_fa_bit.sv
// One-bit combinational full adder cell, shared by every bit position.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of a single bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit add/subtract engine: one full-adder cell stepped
// LSB-first over WIDTH cycles behind a start/ready/done handshake.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_add_sequencer_if.slave bus
);

  localparam int unsigned     CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;

  fa_bit u_fa_bit (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state, operand shifting and result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1, so the carry seeds to 1 and cin is unused.
          a_d     = bus.op_a;
          b_d     = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.sub | bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          res_d   = {fa_s, res_q[WIDTH-1:1]};
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          carry_d = fa_co;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            // carry_q here is the carry into the MSB.
            sum_d   = {fa_s, res_q[WIDTH-1:1]};
            cout_d  = fa_co;
            ovf_d   = carry_q ^ fa_co;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags decode straight from state; results come from registers.
  always_comb begin
    bus.ready = (state_q == IDLE);
    bus.done  = (state_q == DONE);
    bus.sum   = sum_q;
    bus.cout  = cout_q;
    bus.ovf   = ovf_q;
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench: timestamp-based reference model plus directed and
// random stimulus for the serial add/subtract engine.
module tb_serial_add_sequencer;
  import serial_add_sequencer_pkg::*;

  localparam int unsigned W  = 32;
  localparam int          WI = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_add_sequencer_if #(.WIDTH(W)) bus ();

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_err  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An operation accepted at edge number acc completes at edge acc+W and the
  // engine is free again after edge acc+W+1; an abort seen on any edge in
  // (acc, acc+W] frees it immediately with no result.
  int         cyc = 0;
  int         acc = 0;
  bit         m_ready = 1'b1;
  bit         m_done  = 1'b0;
  logic [W-1:0] m_sum = '0;
  bit         m_cout = 1'b0;
  bit         m_ovf  = 1'b0;
  logic [W-1:0] p_sum;
  bit         p_cout;
  bit         p_ovf;

  task automatic ref_result(input logic [W-1:0] a, input logic [W-1:0] b, input bit ci,
                            input bit sb, output logic [W-1:0] s, output bit co, output bit ov);
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(sb ? 1'b1 : ci);
    s    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1'b1;
      m_done  = 1'b0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (m_ready) begin
        if (bus.start === 1'b1) begin
          acc     = cyc;
          m_ready = 1'b0;
          ref_result(bus.op_a, bus.op_b, bus.cin, bus.sub, p_sum, p_cout, p_ovf);
        end
      end else if (cyc <= acc + WI) begin
        if (bus.abort === 1'b1) begin
          m_ready = 1'b1;
        end else if (cyc == acc + WI) begin
          m_sum  = p_sum;
          m_cout = p_cout;
          m_ovf  = p_ovf;
          m_done = 1'b1;
        end
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", W'(bus.ready), W'(m_ready));
      check("done",  W'(bus.done),  W'(m_done));
      check("sum",   bus.sum,       m_sum);
      check("cout",  W'(bus.cout),  W'(m_cout));
      check("ovf",   W'(bus.ovf),   W'(m_ovf));
      check("ready_and_done", W'(bus.ready & bus.done), '0);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 3 * WI) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_ready: ready=%b required 1 (timeout)", bus.ready);
    end
  endtask

  // One operation with hand-computed expectations; checks latency too.
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit ci, input bit sb, input logic [W-1:0] e_sum,
                       input bit e_cout, input bit e_ovf);
    int lat = 0;
    @(negedge clk);
    wait_ready();
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = ci;
    bus.sub   = sb;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    bus.cin   = 1'($urandom);
    bus.sub   = 1'($urandom);
    while (lat < WI + 4) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done === 1'b1) break;
    end
    check({name, "_latency"}, W'(lat), W);
    check({name, "_sum"}, bus.sum, e_sum);
    check({name, "_cout"}, W'(bus.cout), W'(e_cout));
    check({name, "_ovf"}, W'(bus.ovf), W'(e_ovf));
    check({name, "_model_sum"}, m_sum, e_sum);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", W'(bus.ready), W'(1));
    check("rst_done",  W'(bus.done),  '0);
    check("rst_sum",   bus.sum,       '0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Arithmetic corner cases.
    do_op("add5p3",  32'h5,         32'h3, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    do_op("wrap",    32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op("sovf",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op("sub7m5",  32'h7,         32'h5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    do_op("sub5m7",  32'h5,         32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("addcin",  32'h10,        32'h20, 1'b1, 1'b0, 32'h0000_0031, 1'b0, 1'b0);

    // Start held high with operands changing while busy.
    @(negedge clk);
    wait_ready();
    bus.op_a  = 32'h1;
    bus.op_b  = 32'h2;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < WI + 4) begin
      @(negedge clk);
      bus.op_a = $urandom;
      bus.op_b = $urandom;
      bus.cin  = 1'($urandom);
      bus.sub  = 1'($urandom);
      @(posedge clk);
      lat++;
      #1;
      if (bus.done === 1'b1) break;
    end
    check("held_latency", W'(lat), W);
    check("held_sum", bus.sum, 32'h3);
    @(posedge clk);
    #1;
    check("held_ready_after_done", W'(bus.ready), W'(1));
    @(posedge clk);
    #1;
    check("held_second_accepted", W'(bus.ready), '0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_ready();

    // Abort on the 10th RUN cycle leaves the previous result in place.
    do_op("pre_abort", 32'h5, 32'h3, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    @(negedge clk);
    wait_ready();
    bus.op_a  = 32'h10;
    bus.op_b  = 32'h20;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", W'(bus.ready), W'(1));
    check("abort_done",  W'(bus.done),  '0);
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (WI) @(negedge clk);
    check("abort_sum_kept", bus.sum, 32'h0000_0008);

    // Asynchronous reset between edges in the middle of RUN.
    @(negedge clk);
    bus.op_a  = 32'h1234;
    bus.op_b  = 32'h1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ready", W'(bus.ready), W'(1));
    check("arst_done",  W'(bus.done),  '0);
    check("arst_sum",   bus.sum,       '0);
    check("arst_cout",  W'(bus.cout),  '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 32'h1, 32'h1, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

    // Random traffic, including stray starts and aborts in every state.
    repeat (6000) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.abort = ($urandom_range(0, 47) == 0);
      bus.op_a  = pick();
      bus.op_b  = pick();
      bus.cin   = 1'($urandom);
      bus.sub   = 1'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (WI + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
